// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: round-robin grant of two requesters onto one fa_1bit, WIDTH+2 cycles per op.
// Requests are sampled only in IDLE; optional subtract mode via SERIAL_ADD_CTRL_SUB_EN (adds sub0/sub1).

module ha_1bit (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b;
   assign cout = a & b;
endmodule

module fa_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s1;
   logic c1;
   logic c2;

   ha_1bit u_ha0 (.a(a),  .b(b),   .sum(s1),  .cout(c1));
   ha_1bit u_ha1 (.a(s1), .b(cin), .sum(sum), .cout(c2));

   assign cout = c1 | c2;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_CTRL_SUB_EN
   input  logic             sub0,
   input  logic             sub1,
`endif
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             owner,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] res;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;

   logic             grant;
   logic             winner;
   logic             step;
   logic             finish;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             sub_sel;
   logic             fa_sum;
   logic             fa_cout;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      winner    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant     = 1'b1;
               // On a tie the requester not served last time wins
               winner    = (req0 && req1) ? ~last : req1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_STEP) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign a_sel = winner ? a1 : a0;
   assign b_sel = winner ? b1 : b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
   assign sub_sel = winner ? sub1 : sub0;
`else
   assign sub_sel = 1'b0;
`endif

   fa_1bit u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New bit enters MSB-side; after WIDTH steps the word is LSB-aligned
   assign res_sh = {fa_sum, res};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         last  <= 1'b1;
         owner <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         if (grant) begin
            sa    <= a_sel;
            sb    <= b_sel ^ {WIDTH{sub_sel}};
            carry <= sub_sel;
            cnt   <= '0;
            owner <= winner;
            last  <= winner;
         end else if (step) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            res   <= res_sh[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
         end
         if (finish) begin
            sum  <= res_sh;
            cout <= fa_cout;
         end
         ack0 <= finish & ~owner;
         ack1 <= finish &  owner;
         busy <= (state_nxt != IDLE);
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with WIDTH = 8.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
`ifdef SERIAL_ADD_CTRL_SUB_EN
   logic         sub0, sub1;
`endif
   logic         ack0, ack1, busy, owner, cout;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .req1  (req1),
      .a0    (a0),
      .b0    (b0),
      .a1    (a1),
      .b1    (b1),
`ifdef SERIAL_ADD_CTRL_SUB_EN
      .sub0  (sub0),
      .sub1  (sub1),
`endif
      .ack0  (ack0),
      .ack1  (ack1),
      .busy  (busy),
      .owner (owner),
      .sum   (sum),
      .cout  (cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation from a single requester and reports what was observed.
   task automatic do_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] s, output logic c,
                        output logic own, output logic other_seen, output int busy_cnt,
                        output logic ack_after, output logic busy_after);
      lat = -1; s = '0; c = 1'b0; own = 1'b0; other_seen = 1'b0;
      if (sel == 1'b0) begin a0 = a; b0 = b; req0 = 1'b1; end
      else             begin a1 = a; b1 = b; req1 = 1'b1; end
      tick();
      busy_cnt = busy ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (busy) busy_cnt++;
         if ((sel == 1'b0) ? ack1 : ack0) other_seen = 1'b1;
         if ((sel == 1'b0) ? ack0 : ack1) begin
            lat = i; s = sum; c = cout; own = owner;
            break;
         end
      end
      if (sel == 1'b0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      ack_after  = (sel == 1'b0) ? ack0 : ack1;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (ack0 !== 1'b0)  begin errors++; $display("FAIL reset_ack0 got %b exp 0", ack0); end
      checks++; if (ack1 !== 1'b0)  begin errors++; $display("FAIL reset_ack1 got %b exp 0", ack1); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b exp 0", owner); end
      checks++; if (sum !== 8'h00)  begin errors++; $display("FAIL reset_sum got %h exp 00", sum); end
      checks++; if (cout !== 1'b0)  begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add_req0();
      int lat, bc; logic [W-1:0] s; logic c, own, oth, aa, ba;
      do_op(1'b0, 8'h5A, 8'h33, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (lat !== W)     begin errors++; $display("FAIL t1_latency got %0d exp %0d", lat, W); end
      checks++; if (s !== 8'h8D)   begin errors++; $display("FAIL t1_sum got %h exp 8d", s); end
      checks++; if (c !== 1'b0)    begin errors++; $display("FAIL t1_cout got %b exp 0", c); end
      checks++; if (own !== 1'b0)  begin errors++; $display("FAIL t1_owner got %b exp 0", own); end
      checks++; if (oth !== 1'b0)  begin errors++; $display("FAIL t1_ack1_seen got %b exp 0", oth); end
      checks++; if (aa !== 1'b0)   begin errors++; $display("FAIL t1_ack_width got %b exp 0", aa); end
      checks++; if (ba !== 1'b0)   begin errors++; $display("FAIL t1_busy_after got %b exp 0", ba); end
   endtask

   task automatic test_add_req1_carry();
      int lat, bc; logic [W-1:0] s; logic c, own, oth, aa, ba;
      do_op(1'b1, 8'hFF, 8'h01, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (lat !== W)     begin errors++; $display("FAIL t2_latency got %0d exp %0d", lat, W); end
      checks++; if (s !== 8'h00)   begin errors++; $display("FAIL t2_sum got %h exp 00", s); end
      checks++; if (c !== 1'b1)    begin errors++; $display("FAIL t2_cout got %b exp 1", c); end
      checks++; if (own !== 1'b1)  begin errors++; $display("FAIL t2_owner got %b exp 1", own); end
      checks++; if (oth !== 1'b0)  begin errors++; $display("FAIL t2_ack0_seen got %b exp 0", oth); end
      checks++; if (bc !== W + 1)  begin errors++; $display("FAIL t2_busy_cycles got %0d exp %0d", bc, W + 1); end
      checks++; if (aa !== 1'b0)   begin errors++; $display("FAIL t2_ack_width got %b exp 0", aa); end
   endtask

   task automatic test_tie_after_reset();
      int t0, t1; logic [W-1:0] s0, s1;
      t0 = -1; t1 = -1; s0 = '0; s1 = '0;
      rst_n = 1'b0;
      a0 = 8'd1; b0 = 8'd2; a1 = 8'd3; b1 = 8'd4;
      req0 = 1'b1; req1 = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (ack0 && t0 < 0) begin t0 = t; s0 = sum; end
         if (ack1) begin t1 = t; s1 = sum; break; end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
      checks++; if (t0 !== W + 1)  begin errors++; $display("FAIL t3_first_ack0 got %0d exp %0d", t0, W + 1); end
      checks++; if (s0 !== 8'h03)  begin errors++; $display("FAIL t3_sum0 got %h exp 03", s0); end
      checks++; if (s1 !== 8'h07)  begin errors++; $display("FAIL t3_sum1 got %h exp 07", s1); end
      checks++; if (t1 - t0 !== W + 2) begin errors++; $display("FAIL t3_ack_gap got %0d exp %0d", t1 - t0, W + 2); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bc; logic [W-1:0] s; logic c, own, oth, aa, ba; logic acked;
      acked = 1'b0;
      a0 = 8'hF0; b0 = 8'h0F; req0 = 1'b1;
      tick();
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL t4_busy got %b exp 0", busy); end
      checks++; if (sum !== 8'h00)  begin errors++; $display("FAIL t4_sum got %h exp 00", sum); end
      checks++; if (cout !== 1'b0)  begin errors++; $display("FAIL t4_cout got %b exp 0", cout); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL t4_owner got %b exp 0", owner); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack0 || ack1) acked = 1'b1;
      end
      rst_n = 1'b1;
      do_op(1'b0, 8'hF0, 8'h0F, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (acked !== 1'b0) begin errors++; $display("FAIL t4_ack_in_reset got %b exp 0", acked); end
      checks++; if (lat !== W)      begin errors++; $display("FAIL t4_latency got %0d exp %0d", lat, W); end
      checks++; if (s !== 8'hFF)    begin errors++; $display("FAIL t4_sum_after got %h exp ff", s); end
      checks++; if (c !== 1'b0)     begin errors++; $display("FAIL t4_cout_after got %b exp 0", c); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq; int n; logic both;
      seq = '0; n = 0; both = 1'b0;
      a0 = 8'd10; b0 = 8'd20; a1 = 8'd30; b1 = 8'd40;
      req0 = 1'b1; req1 = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (ack0 && ack1) both = 1'b1;
         if (ack0 || ack1) begin
            if (n < 4) seq[n] = ack1;
            n++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
      checks++; if (n !== 4)          begin errors++; $display("FAIL t5_ack_count got %0d exp 4", n); end
      checks++; if (seq !== 4'b1010)  begin errors++; $display("FAIL t5_ack_order got %b exp 1010 (bit0 first)", seq); end
      checks++; if (both !== 1'b0)    begin errors++; $display("FAIL t5_dual_ack got %b exp 0", both); end
   endtask

`ifdef SERIAL_ADD_CTRL_SUB_EN
   task automatic test_subtract();
      int lat, bc; logic [W-1:0] s; logic c, own, oth, aa, ba;
      sub0 = 1'b1;
      do_op(1'b0, 8'h10, 8'h01, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (s !== 8'h0F) begin errors++; $display("FAIL t6_sub_sum got %h exp 0f", s); end
      checks++; if (c !== 1'b1)  begin errors++; $display("FAIL t6_sub_cout got %b exp 1", c); end
      do_op(1'b0, 8'h01, 8'h02, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (s !== 8'hFF) begin errors++; $display("FAIL t6_borrow_sum got %h exp ff", s); end
      checks++; if (c !== 1'b0)  begin errors++; $display("FAIL t6_borrow_cout got %b exp 0", c); end
      sub0 = 1'b0;
      do_op(1'b0, 8'h01, 8'h02, lat, s, c, own, oth, bc, aa, ba);
      checks++; if (s !== 8'h03) begin errors++; $display("FAIL t6_add_sum got %h exp 03", s); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      sub0 = 1'b0; sub1 = 1'b0;
`endif
      test_reset();
      test_add_req0();
      test_add_req1_carry();
      test_reset_mid_run();
      test_tie_after_reset();
      test_back_to_back();
`ifdef SERIAL_ADD_CTRL_SUB_EN
      test_subtract();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. Two requesters share one 1-bit full-adder datapath: a round-robin arbiter grants one of them, the operands are latched, and `WIDTH` LSB-first add steps run through a single `fa_1bit` instance with a registered carry. The block then returns the sum, the carry-out and a one-cycle acknowledge to the winning requester. It sits between the lab's operand sources and the shared `fa_1bit` / `ha_1bit` arithmetic cells.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req0`, `req1` input 1 each: request from requester 0 / 1. Held high until that requester's ack.
- `a0`, `b0`, `a1`, `b1` input `WIDTH` each: operands. Sampled only on the grant edge.
- `ack0`, `ack1` output 1 each: one-cycle completion pulse to requester 0 / 1.
- `busy` output 1: high in RUN and DONE.
- `owner` output 1: index of the requester currently or last served.
- `sum` output `WIDTH`: result. Held until the next DONE.
- `cout` output 1: final carry. Held with `sum`.

## Operation

**States:** IDLE, RUN, DONE.

**IDLE**
- `req0`/`req1` are sampled on each edge.
- If either is high, grant:
  - Single request: that requester wins.
  - Both requests: the requester not equal to `last` wins (`last` resets to 1, so requester 0 wins the first tie).
- On the grant edge:
  - Latch the winner's `a` and `b` into shift registers `sa` and `sb`.
  - `carry <= 0`; `cnt <= 0`; `owner <= winner`; `last <= winner`.
  - Go to RUN.

**RUN**
- Each edge, one `fa_1bit` step: `i0 = sa[0]`, `i1 = sb[0]`, `cin = carry`.
- Updates on the same edge:
  - `fa.sum` is shifted into the result register MSB-side.
  - `sa` and `sb` shift right.
  - `carry <= fa.cout`.
  - `cnt` increments.
- On the edge where `cnt == WIDTH-1`, after the final step:
  - Load the output registers `sum` and `cout` from the result register and `carry` (the result register is internal; `sum`/`cout` change only here).
  - Go to DONE.
- Requests arriving during RUN are not sampled. A requester that drops `req` mid-RUN still receives its ack.

**DONE**
- `ack[owner] = 1` for exactly this cycle; the other ack stays 0.
- The next edge returns to IDLE.

**Arithmetic**
- Plain modulo-2^WIDTH add.
- `cout` is bit `WIDTH` of `a + b`.
- No saturation.

**Reset**
- Asserting `rst_n` low at any time, including mid-RUN:
  - Immediately forces IDLE, `cnt = 0`, `carry = 0`, `last = 1`.
  - Outputs go to their reset values; no ack is issued for the aborted operation.
- Reset values: `ack0 = 0`, `ack1 = 0`, `busy = 0`, `owner = 0`, `sum = 0`, `cout = 0`.

## Timing

- Grant on edge k. RUN occupies edges k+1 … k+WIDTH.
- `sum`/`cout` update and DONE is entered on edge k+WIDTH.
- `ack` is high for the single cycle between edges k+WIDTH and k+WIDTH+1.
- IDLE is re-entered at edge k+WIDTH+1; the earliest next grant is edge k+WIDTH+2.
- A requester must deassert `req` no later than edge k+WIDTH+1. A `req` still high at edge k+WIDTH+2 is treated as a new request.
- Throughput: one operation per `WIDTH+2` cycles.
- With both requests held continuously, grants alternate 0, 1, 0, 1, …
- `busy` rises on edge k and falls on edge k+WIDTH+1.
- `ack0`/`ack1` and `busy` are registered outputs, with no combinational path from `req` to any output.

## Configuration

Macro: `SERIAL_ADD_CTRL_SUB_EN`

**Defined**
- Adds input ports `sub0` and `sub1` (1 bit each), latched with the operands on the grant edge.
- When the latched `sub` is 1:
  - `b` is inverted before loading into `sb`.
  - `carry` initialises to 1.
  - Result is `a - b` modulo 2^WIDTH; `cout = 1` means no borrow.
- When the latched `sub` is 0, the operation is an add.

**Not defined**
- `sub0`/`sub1` are absent.
- Every operation is an add.

## Test plan

Run all scenarios with `WIDTH = 8`.

1. `req0 = 1`, `a0 = 0x5A`, `b0 = 0x33`, granted at edge k → `ack0` high after edge k+8, `sum = 0x8D`, `cout = 0`, `owner = 0`, `ack1` never high.
2. `req1 = 1`, `a1 = 0xFF`, `b1 = 0x01` → `sum = 0x00`, `cout = 1`, `ack1` single-cycle pulse; `busy` high for exactly 9 cycles.
3. First edge after reset, `req0` and `req1` high simultaneously and held (`a0 = 1`, `b0 = 2`, `a1 = 3`, `b1 = 4`) → requester 0 served first (`sum = 0x03`), then requester 1 (`sum = 0x07`); `ack1` follows `ack0` by exactly 10 cycles.
4. `rst_n` pulsed low 3 cycles into RUN of `0xF0 + 0x0F` → `busy`, `sum`, `cout` and `owner` are 0 immediately; no ack. After reset releases with `req0` still high, a fresh grant completes with `sum = 0xFF`.
5. Both requests held high for 40 cycles → the ack sequence is 0, 1, 0, 1 with no missed or duplicated pulses.
6. With `SERIAL_ADD_CTRL_SUB_EN` defined:
   - `sub0 = 1`, `0x10 - 0x01` → `sum = 0x0F`, `cout = 1`.
   - `sub0 = 1`, `0x01 - 0x02` → `sum = 0xFF`, `cout = 0`.
